// File: rtl/generic_fifo_ctrl_sync.sv
// generic_fifo_ctrl_sync: single-clock FIFO controller for a small dual-port memory.
// Latency: memory strobes are combinational from the request; flags, count and the
//          rd_valid strobe are registered (one cycle behind the accepted read).
// Backpressure: writes are refused while full and reads while empty. A refused
//               request raises overflow/underflow. flush overrides both requests.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en, rd_en         write / read requests
//   flush                synchronous clear of pointers and count
//   err_clr              clears sticky overflow/underflow (optional build only)
//   mem_wen, mem_waddr   memory write port enable and address
//   mem_ren, mem_raddr   memory read port enable and address
//   rd_valid             memory read data valid this cycle
//   full, empty          fill status
//   almost_full          count >= AFULL_LEVEL
//   almost_empty         count <= AEMPTY_LEVEL
//   count                fill level, 0 .. 2**AWIDTH
//   overflow, underflow  rejected write / rejected read indication
//
// Build option: define GENERIC_FIFO_STICKY_ERR_EN to make overflow/underflow sticky
// until err_clr. Without it they are single-cycle pulses and err_clr is ignored.

module generic_fifo_ctrl_sync #(
  parameter int AWIDTH       = 3,
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              err_clr,
  output logic              mem_wen,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic              mem_ren,
  output logic [AWIDTH-1:0] mem_raddr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AWIDTH:0] PTR_ONE    = 1;
  localparam logic [AWIDTH:0] AFULL_CNT  = (AWIDTH+1)'(AFULL_LEVEL);
  localparam logic [AWIDTH:0] AEMPTY_CNT = (AWIDTH+1)'(AEMPTY_LEVEL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits match.
  logic [AWIDTH:0] wptr, rptr;
  logic [AWIDTH:0] wptr_n, rptr_n, count_n;
  logic            wr_acc, rd_acc;
  logic            full_n, empty_n, afull_n, aempty_n;
  logic            ovf_set, unf_set, ovf_n, unf_n;

  // Acceptance uses the registered flags, so a simultaneous read on a full
  // FIFO does not open room for the write in the same cycle (and likewise no
  // fall-through on an empty FIFO).
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  assign mem_wen   = wr_acc;
  assign mem_waddr = wptr[AWIDTH-1:0];
  assign mem_ren   = rd_acc;
  assign mem_raddr = rptr[AWIDTH-1:0];

  // A request during a flush cycle is ignored, not rejected.
  assign ovf_set = wr_en && full  && !flush;
  assign unf_set = rd_en && empty && !flush;

  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    if (flush) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      if (wr_acc) wptr_n = wptr + PTR_ONE;
      if (rd_acc) rptr_n = rptr + PTR_ONE;
    end
  end

  // The modular pointer difference is the fill level, including the
  // all-ones-plus-one case of a completely full memory.
  always_comb begin
    count_n  = wptr_n - rptr_n;
    empty_n  = (wptr_n == rptr_n);
    full_n   = (wptr_n[AWIDTH] != rptr_n[AWIDTH]) &&
               (wptr_n[AWIDTH-1:0] == rptr_n[AWIDTH-1:0]);
    afull_n  = (count_n >= AFULL_CNT);
    aempty_n = (count_n <= AEMPTY_CNT);
  end

`ifdef GENERIC_FIFO_STICKY_ERR_EN
  // A new error in the clearing cycle keeps the flag set.
  assign ovf_n = ovf_set || (overflow  && !err_clr);
  assign unf_n = unf_set || (underflow && !err_clr);
`else
  assign ovf_n = ovf_set;
  assign unf_n = unf_set;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      full         <= full_n;
      empty        <= empty_n;
      almost_full  <= afull_n;
      almost_empty <= aempty_n;
      // rd_acc is already forced low by flush, so this also clears on flush.
      rd_valid     <= rd_acc;
      overflow     <= ovf_n;
      underflow    <= unf_n;
    end
  end

  // Registered flags must never claim full and empty at once.
  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

endmodule

// File: tb/tb_generic_fifo_ctrl_sync.sv
module tb_generic_fifo_ctrl_sync;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en, flush, err_clr;
  logic       mem_wen, mem_ren, rd_valid;
  logic [2:0] mem_waddr, mem_raddr;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues: expected write addresses, read addresses, and read
  // addresses whose data-valid strobe must follow one cycle later.
  logic [2:0] exp_w[$];
  logic [2:0] exp_r[$];
  logic [2:0] exp_v[$];

  logic       prev_ren = 1'b0;
  logic [2:0] prev_raddr = '0;

  generic_fifo_ctrl_sync #(.AWIDTH(3), .AFULL_LEVEL(6), .AEMPTY_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .err_clr(err_clr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Monitor: sample combinational strobes mid-cycle and pop expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen) begin
        checks++;
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL wen_unexpected: mem_wen=1 waddr=%0d, required no write", mem_waddr);
        end else begin
          logic [2:0] e;
          e = exp_w.pop_front();
          if (mem_waddr !== e) begin
            errors++;
            $display("FAIL waddr: got %0d, required %0d", mem_waddr, e);
          end
        end
      end
      if (mem_ren) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL ren_unexpected: mem_ren=1 raddr=%0d, required no read", mem_raddr);
        end else begin
          logic [2:0] e;
          e = exp_r.pop_front();
          if (mem_raddr !== e) begin
            errors++;
            $display("FAIL raddr: got %0d, required %0d", mem_raddr, e);
          end
        end
      end
      if (rd_valid) begin
        checks++;
        if (exp_v.size() == 0) begin
          errors++;
          $display("FAIL rd_valid_unexpected: rd_valid=1, required 0");
        end else begin
          logic [2:0] e;
          e = exp_v.pop_front();
          if (!prev_ren || prev_raddr !== e) begin
            errors++;
            $display("FAIL rd_valid_align: prev_ren=%0b prev_raddr=%0d, required 1/%0d",
                     prev_ren, prev_raddr, e);
          end
        end
      end
      prev_ren   = mem_ren;
      prev_raddr = mem_raddr;
    end else begin
      prev_ren = 1'b0;
    end
  end

  // Inputs are applied just after a rising edge; the task returns just after the next one.
  task automatic cyc(input logic w, input logic r, input logic f, input logic c);
    wr_en = w; rd_en = r; flush = f; err_clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  // Status vector: {count, full, empty, almost_full, almost_empty, overflow, underflow}
  task automatic chk(input string name, input logic [3:0] c, input logic fu, input logic em,
                     input logic af, input logic ae, input logic ov, input logic un);
    logic [9:0] got, req;
    got = {count, full, empty, almost_full, almost_empty, overflow, underflow};
    req = {c, fu, em, af, ae, ov, un};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got cnt=%0d f/e/af/ae/ov/un=%b, required cnt=%0d f/e/af/ae/ov/un=%b",
               name, got[9:6], got[5:0], req[9:6], req[5:0]);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 4'd0, 0, 1, 0, 1, 0, 0);
    chk_bit("reset_rd_valid", rd_valid, 1'b0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Fill: addresses 0..7, almost_full from count 6, full at 8.
    for (int i = 0; i < 8; i++) begin
      exp_w.push_back(3'(i));
      cyc(1, 0, 0, 0);
      chk($sformatf("fill_%0d", i), 4'(i + 1), i == 7, 0, (i + 1) >= 6, (i + 1) <= 1, 0, 0);
    end
    cyc(1, 0, 0, 0);  // rejected 9th write
    chk("overflow_pulse", 4'd8, 1, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("overflow_clear", 4'd8, 1, 0, 1, 0, 0, 0);

    // Drain: addresses 0..7, rd_valid follows each read by one cycle.
    for (int i = 0; i < 8; i++) begin
      exp_r.push_back(3'(i));
      exp_v.push_back(3'(i));
      cyc(0, 1, 0, 0);
      chk($sformatf("drain_%0d", i), 4'(7 - i), 0, i == 7, (7 - i) >= 6, (7 - i) <= 1, 0, 0);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  // rejected 9th read
    chk("underflow_pulse", 4'd0, 0, 1, 0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk("underflow_clear", 4'd0, 0, 1, 0, 1, 0, 0);

    // Both pointers sit at 8 (address 0). Bring count to 4.
    for (int i = 0; i < 4; i++) begin
      exp_w.push_back(3'(i));
      cyc(1, 0, 0, 0);
    end
    chk("count4", 4'd4, 0, 0, 0, 0, 0, 0);
    // Ten simultaneous cycles: count holds, both address streams wrap.
    for (int i = 0; i < 10; i++) begin
      exp_w.push_back(3'((4 + i) % 8));
      exp_r.push_back(3'(i % 8));
      exp_v.push_back(3'(i % 8));
      cyc(1, 1, 0, 0);
      chk($sformatf("simul_%0d", i), 4'd4, 0, 0, 0, 0, 0, 0);
    end
    // Drain the remaining four: read addresses 2..5.
    for (int i = 0; i < 4; i++) begin
      exp_r.push_back(3'(2 + i));
      exp_v.push_back(3'(2 + i));
      cyc(0, 1, 0, 0);
    end
    chk("drained_after_simul", 4'd0, 0, 1, 0, 1, 0, 0);

    // Empty with both requests: write to address 6 accepted, read rejected.
    exp_w.push_back(3'd6);
    cyc(1, 1, 0, 0);
    chk("empty_both", 4'd1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) begin
      exp_w.push_back(3'((7 + i) % 8));
      cyc(1, 0, 0, i == 0);
    end
    chk("refill_full", 4'd8, 1, 0, 1, 0, 0, 0);
    // Full with both requests: read of address 6 accepted, write rejected.
    exp_r.push_back(3'd6);
    exp_v.push_back(3'd6);
    cyc(1, 1, 0, 0);
    chk("full_both", 4'd7, 0, 0, 1, 0, 1, 0);
    exp_r.push_back(3'd7); exp_v.push_back(3'd7);
    cyc(0, 1, 0, 1);
    exp_r.push_back(3'd0); exp_v.push_back(3'd0);
    cyc(0, 1, 0, 0);
    chk("count5", 4'd5, 0, 0, 0, 0, 0, 0);

    // Flush with both requests: no strobes, cleared next cycle.
    cyc(1, 1, 1, 0);
    chk("flush", 4'd0, 0, 1, 0, 1, 0, 0);
    chk_bit("flush_rd_valid", rd_valid, 1'b0);
    // Pointers restart at address 0.
    for (int i = 0; i < 3; i++) begin
      exp_w.push_back(3'(i));
      cyc(1, 0, 0, 0);
    end
    chk("post_flush_writes", 4'd3, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a write burst.
    wr_en = 1'b1;
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("async_reset", 4'd0, 0, 1, 0, 1, 0, 0);
    chk_bit("async_reset_rd_valid", rd_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Refill after reset, then exercise the error-flag behaviour of this build.
    for (int i = 0; i < 8; i++) begin
      exp_w.push_back(3'(i));
      cyc(1, 0, 0, 0);
    end
    chk("refill_after_reset", 4'd8, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("overflow_again", 4'd8, 1, 0, 1, 0, 1, 0);
`ifdef GENERIC_FIFO_STICKY_ERR_EN
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("sticky_hold_%0d", i), 4'd8, 1, 0, 1, 0, 1, 0);
    end
    cyc(1, 0, 0, 1);  // clear together with a new overflow
    chk("sticky_set_wins", 4'd8, 1, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("sticky_cleared", 4'd8, 1, 0, 1, 0, 0, 0);
`else
    cyc(0, 0, 0, 0);
    chk("pulse_no_clr", 4'd8, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("pulse_with_clr", 4'd8, 1, 0, 1, 0, 1, 0);
`endif
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    checks++;
    if (exp_w.size() != 0 || exp_r.size() != 0 || exp_v.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: w=%0d r=%0d v=%0d pending, required 0",
               exp_w.size(), exp_r.size(), exp_v.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
